// File: rtl/onchip_memory_loader_if.sv
// Bundle of control, byte-stream and on-chip memory signals for the memory loader.
// The slave modport is the loader's view; master is the surrounding system's view.
interface onchip_memory_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_clken;
  logic              busy;
  logic              done;
  logic              pass;
  logic [31:0]       checksum;

  modport slave (
    input  start, abort, base_addr, word_count, in_data, in_valid, mem_readdata,
    output in_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_writedata, mem_clken, busy, done, pass, checksum
  );

  modport master (
    output start, abort, base_addr, word_count, in_data, in_valid, mem_readdata,
    input  in_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_writedata, mem_clken, busy, done, pass, checksum
  );
endinterface

// File: rtl/onchip_memory_loader.sv
// Packs a little-endian byte stream into 32-bit words, writes them to on-chip memory,
// then reads them back and compares the read-back sum against the write checksum.
module onchip_memory_loader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4096
) (
  input logic                   clk,
  input logic                   reset_n,
  onchip_memory_loader_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StWrite, StVerify, StDrain, StFinish} state_e;

  localparam logic [ADDR_W+1:0] DepthW = DEPTH[ADDR_W+1:0];
  localparam logic [ADDR_W:0]   IdxOne = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   wr_idx_q, wr_idx_d;
  logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       checksum_q, checksum_d;
  logic [31:0]       vsum_q, vsum_d;
  logic              pass_q, pass_d;
  logic              rd_pend_q, rd_pend_d;
  logic              clken_q;

  logic [ADDR_W:0]   wr_idx_inc, rd_idx_inc;
  logic [31:0]       vsum_acc;

  assign wr_idx_inc = wr_idx_q + IdxOne;
  assign rd_idx_inc = rd_idx_q + IdxOne;
  assign vsum_acc   = vsum_q + bus.mem_readdata;

  // Works for non-power-of-two DEPTH as long as base < DEPTH and idx < DEPTH.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W:0]   idx);
    logic [ADDR_W+1:0] sum;
    sum = {2'b00, base} + {1'b0, idx};
    if (sum >= DepthW) sum = sum - DepthW;
    return sum[ADDR_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (bus.start) state_d = (bus.word_count == '0) ? StFinish : StLoad;
        StLoad:   if (bus.in_valid && byte_cnt_q == 2'd3) state_d = StWrite;
        StWrite:  state_d = (wr_idx_inc == count_q) ? StVerify : StLoad;
        StVerify: if (rd_idx_inc == count_q) state_d = StDrain;
        StDrain:  state_d = StFinish;
        StFinish: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    base_d     = base_q;
    count_d    = count_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    checksum_d = checksum_q;
    vsum_d     = vsum_q;
    pass_d     = pass_q;
    rd_pend_d  = 1'b0;
    if (bus.abort) begin
      byte_cnt_d = 2'd0;
      if (state_q != StIdle) pass_d = 1'b0;
    end else begin
      rd_pend_d = (state_q == StVerify);
      // Read data lags its address by one cycle.
      if (rd_pend_q) vsum_d = vsum_acc;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            base_d     = bus.base_addr;
            count_d    = bus.word_count;
            wr_idx_d   = '0;
            rd_idx_d   = '0;
            byte_cnt_d = 2'd0;
            checksum_d = '0;
            vsum_d     = '0;
            pass_d     = (bus.word_count == '0);
          end
        end
        StLoad: begin
          if (bus.in_valid) begin
            word_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
        StWrite: begin
          checksum_d = checksum_q + word_q;
          wr_idx_d   = wr_idx_inc;
          rd_idx_d   = '0;
        end
        StVerify: rd_idx_d = rd_idx_inc;
        StDrain:  pass_d = (vsum_acc == checksum_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      count_q    <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      byte_cnt_q <= 2'd0;
      word_q     <= '0;
      checksum_q <= '0;
      vsum_q     <= '0;
      pass_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      clken_q    <= 1'b0;
    end else begin
      base_q     <= base_d;
      count_q    <= count_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      checksum_q <= checksum_d;
      vsum_q     <= vsum_d;
      pass_q     <= pass_d;
      rd_pend_q  <= rd_pend_d;
      clken_q    <= 1'b1;
    end
  end

  always_comb begin
    bus.in_ready       = 1'b0;
    bus.mem_chipselect = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = '0;
    unique case (state_q)
      StLoad: bus.in_ready = 1'b1;
      StWrite: begin
        bus.mem_chipselect = 1'b1;
        bus.mem_write      = 1'b1;
        bus.mem_address    = wrap_addr(base_q, wr_idx_q);
      end
      StVerify: begin
        bus.mem_chipselect = 1'b1;
        bus.mem_address    = wrap_addr(base_q, rd_idx_q);
      end
      default: ;
    endcase
  end

  assign bus.busy           = (state_q != StIdle);
  assign bus.done           = (state_q == StFinish);
  assign bus.pass           = pass_q;
  assign bus.checksum       = checksum_q;
  assign bus.mem_writedata  = word_q;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_clken      = clken_q;

endmodule

// File: doc/onchip_memory_loader.md
ONCHIP_MEMORY_LOADER -- requirements
Module: onchip_memory_loader

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low (ports clk, reset_n).
REQ-002 Parameter ADDR_W, default 12, memory word-address width.
REQ-003 Parameter DEPTH, default 4096, memory depth in 32-bit words.
REQ-004 clk  in  1  rising-edge clock shared with the on-chip memory.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a load when IDLE.
REQ-007 abort  in  1  synchronous; terminates any operation.
REQ-008 base_addr  in  ADDR_W  first word address, sampled on start.
REQ-009 word_count  in  ADDR_W+1  number of words, 0..DEPTH, sampled on start.
REQ-010 in_data  in  8  byte stream data.
REQ-011 in_valid  in  1  in_data valid.
REQ-012 in_ready  out  1  byte accepted when in_valid & in_ready.
REQ-013 mem_address  out  ADDR_W  memory word address.
REQ-014 mem_byteenable  out  4  always 4'hF.
REQ-015 mem_chipselect  out  1  memory access strobe.
REQ-016 mem_write  out  1  write strobe.
REQ-017 mem_writedata  out  32  packed word.
REQ-018 mem_readdata  in  32  memory read data, unregistered output of a registered-address RAM.
REQ-019 mem_clken  out  1  memory clock enable, 1 except during reset.
REQ-020 busy  out  1  high in any state except IDLE.
REQ-021 done  out  1  one-cycle pulse on completion.
REQ-022 pass  out  1  verify result, valid from done until next start.
REQ-023 checksum  out  32  mod-2^32 sum of words written.

Function
REQ-024 States SHALL be IDLE, LOAD, WRITE, VERIFY, DRAIN, FINISH.
REQ-025 IDLE: start SHALL latch base_addr and word_count, clear checksum and pass, and go to LOAD; start SHALL be ignored outside IDLE.
REQ-026 word_count = 0 on start SHALL go directly to FINISH with checksum 0 and pass 1.
REQ-027 LOAD: in_ready SHALL be 1; each accepted byte SHALL be packed little-endian (first byte into bits 7:0); the 4th accepted byte SHALL move to WRITE.
REQ-028 WRITE: for exactly one cycle, mem_chipselect = mem_write = 1, mem_address = base_addr + word index (mod DEPTH), mem_writedata = packed word, and checksum += word; in_ready SHALL be 0.
REQ-029 After WRITE, the block SHALL return to LOAD if words remain, else go to VERIFY with the read index reset to 0.
REQ-030 VERIFY: each cycle, mem_chipselect = 1, mem_write = 0, mem_address = base_addr + read index (mod DEPTH); the index SHALL increment until word_count reads are issued, then the block SHALL go to DRAIN.
REQ-031 mem_readdata for the read issued in cycle N SHALL be summed into a verify accumulator in cycle N+1; DRAIN SHALL last one cycle to capture the final read.
REQ-032 FINISH: pass SHALL be set to (verify sum == checksum), done SHALL pulse for one cycle, and the block SHALL return to IDLE.
REQ-033 Address arithmetic SHALL wrap modulo DEPTH; word_count = DEPTH SHALL write every location once.
REQ-034 abort SHALL force IDLE in the next cycle, deassert all memory strobes, discard partial bytes, leave pass 0, and not pulse done; abort has priority over start.
REQ-035 Outside WRITE and VERIFY, mem_chipselect and mem_write SHALL be 0.

Reset
REQ-036 While reset_n = 0: state IDLE; in_ready, mem_chipselect, mem_write, mem_clken, busy, done, and pass 0; mem_address, mem_writedata, and checksum 0; mem_byteenable 4'hF.
REQ-037 Reset deassertion SHALL take effect on the first rising clk edge with reset_n = 1; mem_clken SHALL be 1 from that edge onward.

Verification
REQ-038 base 0x010, count 2, bytes 01 02 03 04 05 06 07 08 -> writes 0x04030201@0x010 and 0x08070605@0x011; checksum 0x0C0A0806; pass 1; done pulses once.
REQ-039 base 0xFFF, count 2 -> writes at 0xFFF then 0x000; reads issued in the same order.
REQ-040 Same load, memory model corrupts word 0x011 -> pass 0, checksum unchanged.
REQ-041 in_valid toggling every other cycle -> no lost or duplicated bytes; exactly one write per 4 accepted bytes.
REQ-042 abort after 6 bytes of count 4 -> exactly one write, no done, busy 0 next cycle; next start proceeds normally.
REQ-043 reset_n asserted mid-WRITE -> strobes drop immediately (asynchronous); count 0 start after release -> done after 1 cycle, pass 1, no memory access.
